// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ccff_state_e;

  localparam int CCFF_DEFAULT_CHAIN_LEN = 64;

  // Bits still waiting in the byte buffer: a buffer at index idx has width-idx left.
  function automatic int bits_left(input logic vld, input int idx, input int width);
    if (vld) begin
      return width - idx;
    end else begin
      return 0;
    end
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Packs bits leaving the chain tail into readback bytes, first-out in the LSB;
// a partial byte is flushed zero-padded when the load completes.
module ccff_rb_packer #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic              i_flush,
  input  logic              i_tail,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_next;
  logic [IDX_W-1:0]  r_idx;

  // Accumulator with the current tail bit dropped into its slot.
  always_comb begin
    w_acc_next        = r_acc;
    w_acc_next[r_idx] = i_tail;
  end

  // Collect tail bits; emit a byte when full or when the final shift flushes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_idx   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clear) begin
        r_acc <= '0;
        r_idx <= '0;
      end else if (i_shift) begin
        if (r_idx == LAST_IDX || i_flush) begin
          o_data  <= w_acc_next;
          o_valid <= 1'b1;
          r_acc   <= '0;
          r_idx   <= '0;
        end else begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes a byte stream onto a configuration chain through a gated prog_clk
// and returns the displaced chain contents as readback bytes.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_DEFAULT_CHAIN_LEN,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  ccff_state_e       r_state;
  logic [DATA_W-1:0] r_buf;
  logic              r_buf_vld;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_done;

  logic w_clk_en;
  logic w_last_bit;
  logic w_ready;
  logic w_accept;
  logic w_final;
  int   w_pending;

  assign w_clk_en   = (r_state == LOAD) && r_buf_vld;
  assign w_last_bit = (r_bit_idx == LAST_IDX);
  // Bits already shifted plus bits still buffered; no new byte once these cover the chain.
  assign w_pending  = int'(r_bit_cnt) + bits_left(r_buf_vld, int'(r_bit_idx), DATA_W);
  assign w_ready    = (r_state == LOAD) && (!r_buf_vld || (w_last_bit && w_clk_en))
                      && (w_pending < CHAIN_LEN);
  assign w_accept   = w_ready && s_valid;
  assign w_final    = w_clk_en && (r_bit_cnt == LAST_CNT);

  // Loader FSM, byte buffer and bit counters.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      r_state   <= IDLE;
      r_buf     <= '0;
      r_buf_vld <= 1'b0;
      r_bit_idx <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= LOAD;
            r_done    <= 1'b0;
            r_buf     <= '0;
            r_buf_vld <= 1'b0;
            r_bit_idx <= '0;
            r_bit_cnt <= '0;
          end
        end
        LOAD: begin
          if (start) begin
            r_buf     <= '0;
            r_buf_vld <= 1'b0;
            r_bit_idx <= '0;
            r_bit_cnt <= '0;
          end else begin
            if (w_clk_en) begin
              r_buf     <= r_buf >> 1;
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (w_last_bit) begin
                r_buf_vld <= 1'b0;
              end
            end
            // A byte taken on the last-bit cycle replaces the drained one without a bubble.
            if (w_accept) begin
              r_buf     <= s_data;
              r_buf_vld <= 1'b1;
              r_bit_idx <= '0;
            end
            if (w_final) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_buf_vld <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  ccff_rb_packer #(
    .DATA_W (DATA_W)
  ) u_rb_packer (
    .i_clk   (prog_clk),
    .i_rst_n (prog_reset_n),
    .i_clear (start),
    .i_shift (w_clk_en),
    .i_flush (w_final),
    .i_tail  (ccff_tail),
    .o_data  (rb_data),
    .o_valid (rb_valid)
  );

  assign s_ready     = w_ready;
  assign ccff_head   = r_buf[0];
  assign ccff_clk_en = w_clk_en;
  assign busy        = (r_state == LOAD);
  assign done        = r_done;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 64-flop and a 13-flop chain model driven by
// two loader instances, with queued readback expectations.
module tb_ccff_bitstream_loader;

  localparam logic [63:0] INIT_RB = 64'hDEADBEEFCAFEF00D;

  function automatic logic [63:0] rev64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return r;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start64 = 1'b0, start13 = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid64 = 1'b0, s_valid13 = 1'b0;
  logic       s_ready64, head64, en64, rb_valid64, busy64, done64;
  logic       s_ready13, head13, en13, rb_valid13, busy13, done13;
  logic [7:0] rb_data64, rb_data13;

  logic [63:0] chain64 = rev64(INIT_RB);
  logic [12:0] chain13 = 13'h1ACE;
  int shifts64 = 0, shifts13 = 0;
  int run64 = 0, last_run64 = 0, pops13 = 0;
  int errors = 0, checks = 0;
  logic [7:0] q64[$];
  logic [7:0] q13[$];

  ccff_bitstream_loader #(.CHAIN_LEN(64), .DATA_W(8)) dut64 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start64), .s_data(s_data),
    .s_valid(s_valid64), .s_ready(s_ready64), .ccff_head(head64), .ccff_clk_en(en64),
    .ccff_tail(chain64[63]), .rb_data(rb_data64), .rb_valid(rb_valid64),
    .busy(busy64), .done(done64));

  ccff_bitstream_loader #(.CHAIN_LEN(13), .DATA_W(8)) dut13 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start13), .s_data(s_data),
    .s_valid(s_valid13), .s_ready(s_ready13), .ccff_head(head13), .ccff_clk_en(en13),
    .ccff_tail(chain13[12]), .rb_data(rb_data13), .rb_valid(rb_valid13),
    .busy(busy13), .done(done13));

  // Behavioural chains: shift on every enabled prog_clk edge.
  always @(posedge clk) begin
    if (en64) begin
      chain64  <= {chain64[62:0], head64};
      shifts64 <= shifts64 + 1;
    end
    if (en13) begin
      chain13  <= {chain13[11:0], head13};
      shifts13 <= shifts13 + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Readback scoreboard and enable run-length tracking.
  always @(negedge clk) begin
    if (en64) run64++;
    else if (run64 > 0) begin
      last_run64 = run64;
      run64 = 0;
    end
    if (rb_valid64) begin
      if (q64.size() == 0) fail_note("rb64_extra");
      else check("rb64_data", rb_data64, q64.pop_front());
    end
    if (rb_valid13) begin
      pops13++;
      if (q13.size() == 0) fail_note("rb13_extra");
      else check("rb13_data", rb_data13, q13.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start13 = 1'b1;
    else start64 = 1'b1;
    tick();
    start13 = 1'b0;
    start64 = 1'b0;
  endtask

  // Expected readback = current chain contents, tail first, zero-padded.
  task automatic push_model(input bit sel);
    logic [7:0] b;
    if (sel) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 8; j++) b[j] = (8*k + j < 13) ? chain13[12-(8*k+j)] : 1'b0;
        q13.push_back(b);
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        for (int j = 0; j < 8; j++) b[j] = chain64[63-(8*k+j)];
        q64.push_back(b);
      end
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    int t = 0;
    logic rdy = 1'b0;
    s_data = b;
    if (sel) s_valid13 = 1'b1;
    else s_valid64 = 1'b1;
    while (!rdy && t < 300) begin
      @(negedge clk);
      rdy = sel ? s_ready13 : s_ready64;
      t++;
    end
    if (!rdy) fail_note("send_timeout");
    tick();
    s_valid13 = 1'b0;
    s_valid64 = 1'b0;
  endtask

  task automatic wait_done64();
    int t = 0;
    @(negedge clk);
    while (!done64 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!done64) fail_note("done64_timeout");
  endtask

  typedef struct {
    logic [63:0] data;
    int          stall;
    logic [63:0] exp_rb;
    int          exp_run;
  } vec_t;

  vec_t        tbl[3];
  logic [63:0] snap;
  logic [63:0] data2;
  logic [12:0] exp13;
  int          base;
  int          t;

  initial begin
    tbl[0] = '{64'h0807060504030201, 0, INIT_RB, 64};
    tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 0, 64'h0807060504030201, 64};
    tbl[2] = '{64'h81E70FF03CC3A55A, 5, 64'hFFFFFFFFFFFFFFFF, 40};

    tick();
    tick();
    @(negedge clk);
    check("rst_ready", s_ready64, 1'b0);
    check("rst_clk_en", en64, 1'b0);
    check("rst_rb", {rb_valid64, rb_data64}, 9'h000);
    check("rst_busy_done", {busy64, done64, busy13, done13}, 4'h0);
    check("rst_head", head64, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      base = shifts64;
      pulse_start(1'b0);
      for (int k = 0; k < 8; k++) q64.push_back(tbl[i].exp_rb[8*k +: 8]);
      for (int k = 0; k < 8; k++) begin
        send_byte(1'b0, tbl[i].data[8*k +: 8]);
        if (k == 2 && tbl[i].stall > 0) begin
          repeat (8) tick();
          snap = chain64;
          for (int s = 0; s < tbl[i].stall; s++) begin
            @(negedge clk);
            check("stall_clk_en", en64, 1'b0);
            check("stall_hold", chain64, snap);
            tick();
          end
        end
      end
      wait_done64();
      check("load_shifts", shifts64 - base, 64);
      check("load_chain", chain64, rev64(tbl[i].data));
      check("load_busy", busy64, 1'b0);
      tick();
      tick();
      check("load_rb_left", q64.size(), 0);
      check("load_run", last_run64, tbl[i].exp_run);
      check("load_done_hold", {done64, en64}, 2'b10);
    end

    // Restart after 20 shifts: the next 64 shifts alone define the chain.
    base = shifts64;
    pulse_start(1'b0);
    push_model(1'b0);
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    send_byte(1'b0, 8'h33);
    t = 0;
    while (shifts64 - base < 20 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("restart_at20", shifts64 - base, 20);
    check("restart_rb_popped", q64.size(), 6);
    q64.delete();
    tick();
    pulse_start(1'b0);
    base = shifts64;
    push_model(1'b0);
    data2 = 64'hC0FFEE0012345678;
    for (int k = 0; k < 8; k++) send_byte(1'b0, data2[8*k +: 8]);
    wait_done64();
    check("restart_shifts", shifts64 - base, 64);
    check("restart_chain", chain64, rev64(data2));
    tick();
    tick();
    check("restart_rb_left", q64.size(), 0);

    // One-cycle reset in the middle of a load.
    pulse_start(1'b0);
    push_model(1'b0);
    send_byte(1'b0, 8'h5A);
    send_byte(1'b0, 8'h3C);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q64.delete();
    @(negedge clk);
    check("mrst_outs", {s_ready64, head64, en64, rb_valid64, busy64, done64}, 6'h00);
    check("mrst_rb_data", rb_data64, 8'h00);
    tick();
    s_data = 8'h77;
    s_valid64 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check("mrst_idle", {s_ready64, en64, busy64}, 3'b000);
      tick();
    end
    s_valid64 = 1'b0;

    // 13-flop chain: partial final byte and zero-padded readback.
    base = shifts13;
    pulse_start(1'b1);
    push_model(1'b1);
    send_byte(1'b1, 8'hAB);
    send_byte(1'b1, 8'hCD);
    s_data = 8'hEE;
    s_valid13 = 1'b1;
    t = 0;
    @(negedge clk);
    while (!done13 && t < 100) begin
      check("c13_no_ready", s_ready13, 1'b0);
      @(negedge clk);
      t++;
    end
    if (!done13) fail_note("done13_timeout");
    check("c13_rb_with_done", rb_valid13, 1'b1);
    s_valid13 = 1'b0;
    for (int k = 0; k < 13; k++) exp13[12-k] = 13'h0DAB >> k;
    check("c13_shifts", shifts13 - base, 13);
    check("c13_chain", chain13, exp13);
    tick();
    tick();
    check("c13_rb_count", pops13, 2);
    check("c13_rb_left", q13.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain driver that sits directly upstream of the switch-block/tile configuration chain.
- Accepts bitstream bytes over a valid/ready stream and serializes them onto `ccff_head`, one bit per enabled `prog_clk` edge.
- Drives `ccff_clk_en` to an external clock gate feeding the chain's `prog_clk`; the chain has no shift enable of its own.
- Captures the bits leaving `ccff_tail` as readback bytes, so previous configuration contents can be checked.

Parameters:
- CHAIN_LEN, 64, number of configuration flops in the chain (16 muxes x 4 bits), >=1
- DATA_W, 8, input/readback byte width
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived, not overridden)

Ports:
- prog_clk  input  1  configuration clock
- prog_reset_n  input  1  reset, synchronous and active-low
- start  input  1  one-cycle pulse: begin (or restart) a load
- s_data  input  DATA_W  bitstream byte, LSB shifted first
- s_valid  input  1  s_data valid
- s_ready  output  1  loader accepts s_data this cycle
- ccff_head  output  1  serial config bit into chain head
- ccff_clk_en  output  1  chain shifts on the prog_clk edge ending a cycle where this is 1
- ccff_tail  input  1  serial bit out of chain tail
- rb_data  output  DATA_W  readback byte (bits exiting tail, first-out in LSB)
- rb_valid  output  1  one-cycle pulse, rb_data valid
- busy  output  1  state == LOAD
- done  output  1  chain fully loaded; held until next start

Behaviour:
- Reset (prog_reset_n=0 sampled at an edge):
  - state=IDLE; s_ready=0, ccff_head=0, ccff_clk_en=0, rb_valid=0, rb_data=0, busy=0, done=0.
  - Counters and buffers are zeroed.
  - Reset mid-load abandons the load; chain contents are undefined.
- Outputs are driven directly from flops only: no combinational path from any input to `ccff_head`, `ccff_clk_en`, `rb_*`, `busy` or `done`. `s_ready` is the one exception and may depend on state and buffer flops only.
- FSM:
  - IDLE --start--> LOAD.
  - LOAD --(bit_cnt==CHAIN_LEN)--> DONE.
  - DONE --start--> LOAD.
  - LOAD --start--> LOAD: restart. Clear bit_cnt, the byte buffer and the readback accumulator; discard any held byte.
- Byte buffer: shift register `buf[DATA_W-1:0]`, a `buf_vld` flag and a bit index 0..DATA_W-1.
  - `ccff_head = buf[0]`.
  - `ccff_clk_en = (state==LOAD) && buf_vld`.
- Shift cycle (ccff_clk_en=1):
  - buf shifts right.
  - bit index increments.
  - bit_cnt increments.
  - ccff_tail is sampled into the readback accumulator.
- s_ready = (state==LOAD) && (!buf_vld || (bit_idx==DATA_W-1 && ccff_clk_en)) && (bit_cnt + remaining_bits_in_buf < CHAIN_LEN).
  - A byte accepted on the last-bit cycle loads directly, so there is no bubble: steady-state throughput is 1 bit/cycle.
  - No byte is accepted once the buffered bits cover the chain.
- Stall: if buf_vld=0 in LOAD, ccff_clk_en=0 and the chain holds.
- Termination:
  - When bit_cnt reaches CHAIN_LEN, the loader enters DONE on the same edge as the final shift.
  - ccff_clk_en=0 from the next cycle on.
  - Unused high bits of the final byte (CHAIN_LEN mod DATA_W != 0) are discarded.
  - done=1 is registered in the same cycle.
- Bit order: the first bit shifted ends in the flop nearest ccff_tail.
- Readback:
  - Each shifted tail bit enters rb accumulator position rb_idx.
  - When DATA_W bits are collected: rb_data updates and rb_valid pulses for 1 cycle, one cycle after the DATA_W-th shift.
  - On load completion, a partial accumulator is emitted zero-padded, with rb_valid coincident with done rising.
  - Total readback bytes = ceil(CHAIN_LEN/DATA_W).
- start in IDLE or DONE clears done on the next cycle.
- start simultaneous with s_valid: the byte is not accepted, because s_ready is computed from pre-start state.
- s_valid with s_ready=0: the byte is held by the source; the loader never drops it.

Decomposition:
- Shared package `ccff_loader_pkg`:
  - `ccff_state_e {IDLE, LOAD, DONE}`.
  - Constant `CCFF_DEFAULT_CHAIN_LEN = 64`.
- One natural sub-module: `ccff_rb_packer`, the tail-bit to byte accumulator with flush-on-done.

Test Plan:
- Reset, start, 8 back-to-back bytes 0x01..0x08 with CHAIN_LEN=64 and a behavioural 64-flop chain model:
  - ccff_clk_en high for exactly 64 consecutive cycles.
  - Model contents match, with bit 0 of 0x01 at the tail.
  - done=1; 8 rb bytes of the prior contents.
- Second load of 0xFF x8 after the first:
  - rb_data sequence equals 0x01..0x08.
- Starve s_valid for 5 cycles after byte 3:
  - ccff_clk_en=0 for those cycles.
  - Chain unchanged; final contents still correct; total shifts = 64.
- CHAIN_LEN=13, bytes 0xAB, 0xCD:
  - 13 shifts; top 3 bits of 0xCD discarded.
  - s_ready=0 after byte 2.
  - 2 rb pulses, the second zero-padded above bit 4.
- start pulse after 20 shifts:
  - bit_cnt restarts at 0; the next 64 shifts fully define the chain; done only after those 64.
- prog_reset_n low for 1 cycle mid-load:
  - All outputs 0 on the next cycle; state IDLE; ignores s_valid until start.
